hdmi_channel_framer: RTL and testbench

- Converts the per-cycle HDMI period code (opmode) from the sequencer into per-channel TMDS encoder controls (mode, ctrl, guard), pixel data and aux nibbles for three channels.
- All outputs are delay-matched through a parametrised pipeline.
- Adds runtime-selectable colour scaling, a DVI fallback mode, and a period-sequence checker that flags illegal preamble, guard or data-island timing.
- Sits between hdmi_sequencer/hdmi_aux_packer and the three tmds_encoder instances.

---
 rtl/hdmi_channel_framer_if.sv | 49 ++++
 rtl/hdmi_channel_framer.sv | 191 +++++++++++++++++++
 tb/tb_hdmi_channel_framer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_channel_framer_if.sv
// Bundle between the period sequencer / aux packer side and the channel framer.
// The master drives period code, sync, pixels and aux; the slave returns encoder controls and status.
interface hdmi_channel_framer_if;
   logic [2:0] opmode;
   logic       hsync;
   logic       vsync;
   logic [1:0] scale_mode;
   logic [7:0] pixel0;
   logic [7:0] pixel1;
   logic [7:0] pixel2;
   logic [3:0] aux0;
   logic [3:0] aux1;
   logic [3:0] aux2;
   logic       err_clear;

   logic [1:0] ch0_mode;
   logic [1:0] ch1_mode;
   logic [1:0] ch2_mode;
   logic [1:0] ch0_ctrl;
   logic [1:0] ch1_ctrl;
   logic [1:0] ch2_ctrl;
   logic       ch2_guard;
   logic [7:0] ch0_pix;
   logic [7:0] ch1_pix;
   logic [7:0] ch2_pix;
   logic [3:0] ch0_aux;
   logic [3:0] ch1_aux;
   logic [3:0] ch2_aux;
   logic       seq_error;
   logic [2:0] err_code;
   logic [2:0] chk_state;

   // Fields are sampled every clock; there is no back-pressure, so no valid/ready pair exists.
   modport master (
      output opmode, hsync, vsync, scale_mode, pixel0, pixel1, pixel2,
             aux0, aux1, aux2, err_clear,
      input  ch0_mode, ch1_mode, ch2_mode, ch0_ctrl, ch1_ctrl, ch2_ctrl,
             ch2_guard, ch0_pix, ch1_pix, ch2_pix, ch0_aux, ch1_aux, ch2_aux,
             seq_error, err_code, chk_state
   );

   modport slave (
      input  opmode, hsync, vsync, scale_mode, pixel0, pixel1, pixel2,
             aux0, aux1, aux2, err_clear,
      output ch0_mode, ch1_mode, ch2_mode, ch0_ctrl, ch1_ctrl, ch2_ctrl,
             ch2_guard, ch0_pix, ch1_pix, ch2_pix, ch0_aux, ch1_aux, ch2_aux,
             seq_error, err_code, chk_state
   );
endinterface

// File: rtl/hdmi_channel_framer.sv
// Turns the per-cycle HDMI period code into TMDS encoder controls for three channels,
// scales pixels, delay-matches every field and checks the period sequence.
module hdmi_channel_framer #(
   parameter int DELAY       = 2,
   parameter bit DVI_MODE    = 1'b0,
   parameter int MAX_PACKETS = 18
) (
   input logic                  clk,
   input logic                  rst_n,
   hdmi_channel_framer_if.slave bus
);

   typedef struct packed {
      logic [1:0] m0;
      logic [1:0] m1;
      logic [1:0] m2;
      logic [1:0] c0;
      logic [1:0] c1;
      logic [1:0] c2;
      logic       g;
      logic [7:0] p0;
      logic [7:0] p1;
      logic [7:0] p2;
      logic [3:0] a0;
      logic [3:0] a1;
      logic [3:0] a2;
   } fields_t;

   localparam fields_t IDLE = '{m0: 2'b10, m1: 2'b10, m2: 2'b10,
                                c0: 2'b00, c1: 2'b00, c2: 2'b00, g: 1'b0,
                                p0: 8'd0, p1: 8'd0, p2: 8'd0,
                                a0: 4'd0, a1: 4'd0, a2: 4'd0};

   localparam logic [9:0] MAX_RUN = 10'(MAX_PACKETS * 32);

   typedef enum logic [2:0] {
      S_CTRL, S_VPRE, S_VGUARD, S_VIDEO, S_APRE, S_AGUARD1, S_ADATA, S_AGUARD2
   } chk_state_t;

   function automatic logic [7:0] scale(input logic [7:0] x, input logic [1:0] sm,
                                        input logic ycc_ch);
      logic [8:0] lim;
      lim = 9'd16 + 9'(x >> 1) + 9'(x >> 2) + 9'(x >> 3);
      case (sm)
         2'b01:   scale = lim[7:0];
         2'b10:   scale = ycc_ch ? 8'(lim + 9'(x >> 4)) : lim[7:0];
         default: scale = x;
      endcase
   endfunction

   fields_t    nxt;
   fields_t    pipe [DELAY];
   logic [2:0] eff_op;

   always_comb begin
      nxt    = IDLE;
      eff_op = bus.opmode;
      // In DVI only video survives; every island or preamble code becomes a plain control period.
      if (DVI_MODE && bus.opmode != 3'b011) eff_op = 3'b000;
      case (eff_op)
         3'b111: nxt.c1 = 2'b01;
         3'b110: begin
            nxt.m0 = 2'b00; nxt.m1 = 2'b00; nxt.m2 = 2'b00;
            nxt.g  = 1'b1;
         end
         3'b101: begin
            nxt.c1 = 2'b01; nxt.c2 = 2'b01;
         end
         3'b100: begin
            nxt.m0 = 2'b01; nxt.m1 = 2'b00; nxt.m2 = 2'b00;
         end
         3'b011: begin
            nxt.m0 = 2'b11; nxt.m1 = 2'b11; nxt.m2 = 2'b11;
         end
         3'b001: begin
            nxt.m0 = 2'b01; nxt.m1 = 2'b01; nxt.m2 = 2'b01;
         end
         default: ;
      endcase
      nxt.c0 = {bus.vsync, bus.hsync};
      nxt.p0 = scale(bus.pixel0, bus.scale_mode, 1'b1);
      nxt.p1 = scale(bus.pixel1, bus.scale_mode, 1'b0);
      nxt.p2 = scale(bus.pixel2, bus.scale_mode, 1'b1);
      nxt.a0 = bus.aux0;
      nxt.a1 = bus.aux1;
      nxt.a2 = bus.aux2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DELAY; i++) pipe[i] <= IDLE;
      end else begin
         pipe[0] <= nxt;
         for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign bus.ch0_mode  = pipe[DELAY-1].m0;
   assign bus.ch1_mode  = pipe[DELAY-1].m1;
   assign bus.ch2_mode  = pipe[DELAY-1].m2;
   assign bus.ch0_ctrl  = pipe[DELAY-1].c0;
   assign bus.ch1_ctrl  = pipe[DELAY-1].c1;
   assign bus.ch2_ctrl  = pipe[DELAY-1].c2;
   assign bus.ch2_guard = pipe[DELAY-1].g;
   assign bus.ch0_pix   = pipe[DELAY-1].p0;
   assign bus.ch1_pix   = pipe[DELAY-1].p1;
   assign bus.ch2_pix   = pipe[DELAY-1].p2;
   assign bus.ch0_aux   = pipe[DELAY-1].a0;
   assign bus.ch1_aux   = pipe[DELAY-1].a1;
   assign bus.ch2_aux   = pipe[DELAY-1].a2;

   chk_state_t state;
   chk_state_t tgt;
   logic [9:0] run;
   logic       stay;
   logic       legal;
   logic [2:0] len_code;
   logic       err_det;
   logic [2:0] det_code;
   logic       err_flag;
   logic [2:0] err_cause;

   // tgt is the state implied by the current code; legal moves and resync both land there.
   always_comb begin
      tgt = S_CTRL;
      case (bus.opmode)
         3'b111: tgt = S_VPRE;
         3'b110: tgt = S_VGUARD;
         3'b011: tgt = S_VIDEO;
         3'b101: tgt = S_APRE;
         3'b100: tgt = (state == S_ADATA || state == S_AGUARD2) ? S_AGUARD2 : S_AGUARD1;
         3'b001: tgt = S_ADATA;
         default: tgt = S_CTRL;
      endcase
      stay = (tgt == state);

      legal = 1'b0;
      case (state)
         S_CTRL:    legal = (tgt == S_VPRE) || (tgt == S_APRE);
         S_VPRE:    legal = (tgt == S_VGUARD);
         S_VGUARD:  legal = (tgt == S_VIDEO);
         S_VIDEO:   legal = (tgt == S_CTRL);
         S_APRE:    legal = (tgt == S_AGUARD1);
         S_AGUARD1: legal = (tgt == S_ADATA);
         S_ADATA:   legal = (tgt == S_AGUARD2);
         S_AGUARD2: legal = (tgt == S_CTRL);
         default:   legal = 1'b0;
      endcase

      // Lengths are judged on the run that just ended, when the code moves on.
      len_code = 3'd0;
      case (state)
         S_VPRE, S_APRE:                  if (run != 10'd8) len_code = 3'd1;
         S_VGUARD, S_AGUARD1, S_AGUARD2:  if (run != 10'd2) len_code = 3'd2;
         S_ADATA: begin
            if (run[4:0] != 5'd0)   len_code = 3'd3;
            else if (run > MAX_RUN) len_code = 3'd4;
         end
         default: len_code = 3'd0;
      endcase

      err_det  = !stay && (!legal || len_code != 3'd0);
      det_code = !legal ? 3'd5 : len_code;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_CTRL;
         run       <= 10'd0;
         err_flag  <= 1'b0;
         err_cause <= 3'd0;
      end else begin
         state <= tgt;
         if (stay) run <= (run == 10'd1023) ? run : run + 10'd1;
         else      run <= 10'd1;
         if (err_det && (!err_flag || bus.err_clear)) begin
            err_flag  <= 1'b1;
            err_cause <= det_code;
         end else if (bus.err_clear) begin
            err_flag  <= 1'b0;
            err_cause <= 3'd0;
         end
      end
   end

   // Status flags come straight from the checker registers, one cycle after the offending code.
   assign bus.seq_error = err_flag;
   assign bus.err_code  = err_cause;
   assign bus.chk_state = state;

endmodule

// File: tb/tb_hdmi_channel_framer.sv
// Drives one stimulus stream into an HDMI framer and a DVI framer with different delays,
// comparing every output cycle against a table model plus literal checkpoints.
module tb_hdmi_channel_framer;

   localparam int D0 = 2;
   localparam int D1 = 3;
   localparam logic [48:0] RST_V = {2'd2, 2'd2, 2'd2, 43'd0};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] opmode = 3'b000;
   logic       hsync = 1'b0, vsync = 1'b0, err_clear = 1'b0;
   logic [1:0] scale_mode = 2'b00;
   logic [7:0] pixel0 = 8'd0, pixel1 = 8'd0, pixel2 = 8'd0;
   logic [3:0] aux0 = 4'd0, aux1 = 4'd0, aux2 = 4'd0;
   bit         auto_pix = 1'b1;
   int         cnt = 0;

   int n_checks = 0;
   int n_pass   = 0;

   hdmi_channel_framer_if if0();
   hdmi_channel_framer_if if1();

   assign if0.opmode = opmode;     assign if1.opmode = opmode;
   assign if0.hsync = hsync;       assign if1.hsync = hsync;
   assign if0.vsync = vsync;       assign if1.vsync = vsync;
   assign if0.scale_mode = scale_mode; assign if1.scale_mode = scale_mode;
   assign if0.pixel0 = pixel0;     assign if1.pixel0 = pixel0;
   assign if0.pixel1 = pixel1;     assign if1.pixel1 = pixel1;
   assign if0.pixel2 = pixel2;     assign if1.pixel2 = pixel2;
   assign if0.aux0 = aux0;         assign if1.aux0 = aux0;
   assign if0.aux1 = aux1;         assign if1.aux1 = aux1;
   assign if0.aux2 = aux2;         assign if1.aux2 = aux2;
   assign if0.err_clear = err_clear; assign if1.err_clear = err_clear;

   hdmi_channel_framer #(.DELAY(D0), .DVI_MODE(1'b0), .MAX_PACKETS(18)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0)
   );
   hdmi_channel_framer #(.DELAY(D1), .DVI_MODE(1'b1), .MAX_PACKETS(18)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1)
   );

   wire [48:0] act0 = {if0.ch0_mode, if0.ch1_mode, if0.ch2_mode, if0.ch0_ctrl, if0.ch1_ctrl,
                       if0.ch2_ctrl, if0.ch2_guard, if0.ch0_pix, if0.ch1_pix, if0.ch2_pix,
                       if0.ch0_aux, if0.ch1_aux, if0.ch2_aux};
   wire [48:0] act1 = {if1.ch0_mode, if1.ch1_mode, if1.ch2_mode, if1.ch0_ctrl, if1.ch1_ctrl,
                       if1.ch2_ctrl, if1.ch2_guard, if1.ch0_pix, if1.ch1_pix, if1.ch2_pix,
                       if1.ch0_aux, if1.ch1_aux, if1.ch2_aux};

   // ---------------- model ----------------
   function automatic int sc(input int x, input int sm, input bit ycc_ch);
      int lim;
      lim = 16 + x / 2 + x / 4 + x / 8;
      if (sm == 1) return lim;
      if (sm == 2) return ycc_ch ? lim + x / 16 : lim;
      return x;
   endfunction

   function automatic logic [48:0] model(input bit dvi);
      int m0, m1, m2, c1, c2, g, op, sm;
      m0 = 2; m1 = 2; m2 = 2; c1 = 0; c2 = 0; g = 0;
      op = int'(opmode);
      sm = int'(scale_mode);
      if (dvi && op != 3) op = 0;
      case (op)
         7: c1 = 1;
         6: begin m0 = 0; m1 = 0; m2 = 0; g = 1; end
         5: begin c1 = 1; c2 = 1; end
         4: begin m0 = 1; m1 = 0; m2 = 0; end
         3: begin m0 = 3; m1 = 3; m2 = 3; end
         1: begin m0 = 1; m1 = 1; m2 = 1; end
         default: ;
      endcase
      return {2'(m0), 2'(m1), 2'(m2), vsync, hsync, 2'(c1), 2'(c2), 1'(g),
              8'(sc(int'(pixel0), sm, 1'b1)), 8'(sc(int'(pixel1), sm, 1'b0)),
              8'(sc(int'(pixel2), sm, 1'b1)), aux0, aux1, aux2};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
   endtask

   // ---------------- scoreboards ----------------
   logic [48:0] exp_q0[$];
   logic [48:0] exp_q1[$];

   always @(negedge clk) begin : cmp0
      if (!rst_n) begin
         chk("rst_out0", 64'(act0), 64'(RST_V));
         exp_q0.delete();
         for (int i = 0; i <= D0; i++) exp_q0.push_back(RST_V);
      end else begin
         exp_q0.push_front(model(1'b0));
         chk("pipe0", 64'(act0), 64'(exp_q0[D0]));
         void'(exp_q0.pop_back());
      end
   end

   always @(negedge clk) begin : cmp1
      if (!rst_n) begin
         chk("rst_out1", 64'(act1), 64'(RST_V));
         exp_q1.delete();
         for (int i = 0; i <= D1; i++) exp_q1.push_back(RST_V);
      end else begin
         exp_q1.push_front(model(1'b1));
         chk("pipe1_dvi", 64'(act1), 64'(exp_q1[D1]));
         void'(exp_q1.pop_back());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic hold(input logic [2:0] opm, input int n);
      repeat (n) begin
         opmode = opm;
         if (auto_pix) begin
            cnt++;
            pixel0 = 8'(cnt * 3);
            pixel1 = 8'(cnt * 5 + 1);
            pixel2 = 8'(~cnt);
            aux0 = 4'(cnt);
            aux1 = 4'(cnt >> 1);
            aux2 = 4'(~cnt);
            hsync = cnt[2];
            vsync = cnt[4];
            scale_mode = 2'(cnt >> 3);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic clear_err();
      err_clear = 1'b1;
      hold(3'b000, 1);
      err_clear = 1'b0;
   endtask

   task automatic chk_flags(input string name, input logic e, input logic [2:0] code);
      chk({name, "_err0"}, 64'(if0.seq_error), 64'(e));
      chk({name, "_code0"}, 64'(if0.err_code), 64'(code));
      chk({name, "_err1"}, 64'(if1.seq_error), 64'(e));
      chk({name, "_code1"}, 64'(if1.err_code), 64'(code));
   endtask

   task automatic chk_modes(input string name, input int which, input logic [5:0] m);
      if (which == 0) chk(name, 64'({if0.ch0_mode, if0.ch1_mode, if0.ch2_mode}), 64'(m));
      else            chk(name, 64'({if1.ch0_mode, if1.ch1_mode, if1.ch2_mode}), 64'(m));
   endtask

   task automatic chk_pix(input string name, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2);
      chk({name, "_0"}, 64'({if0.ch0_pix, if0.ch1_pix, if0.ch2_pix}), 64'({e0, e1, e2}));
      chk({name, "_1"}, 64'({if1.ch0_pix, if1.ch1_pix, if1.ch2_pix}), 64'({e0, e1, e2}));
   endtask

   task automatic aux_island(input int data_len);
      hold(3'b101, 8);
      hold(3'b100, 2);
      hold(3'b001, data_len);
      hold(3'b100, 2);
      hold(3'b000, 4);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_modes("reset_modes0", 0, 6'b101010);
      chk_modes("reset_modes1", 1, 6'b101010);
      chk("reset_guard0", 64'(if0.ch2_guard), 64'(0));
      chk_flags("reset", 1'b0, 3'd0);
      rst_n = 1'b1;
      hold(3'b000, 4);

      // Legal aux island, with literal checkpoints at the end of each steady run
      hold(3'b101, 8);
      chk("apre_ctrl0", 64'({if0.ch1_ctrl, if0.ch2_ctrl}), 64'(4'b0101));
      chk("apre_ctrl1_dvi", 64'({if1.ch1_ctrl, if1.ch2_ctrl}), 64'(4'b0000));
      hold(3'b100, 2);
      chk_modes("aguard_modes0", 0, 6'b010000);
      chk("aguard_guard0", 64'(if0.ch2_guard), 64'(0));
      hold(3'b001, 64);
      chk_modes("adata_modes0", 0, 6'b010101);
      chk_modes("adata_modes1_dvi", 1, 6'b101010);
      hold(3'b100, 2);
      hold(3'b000, 4);
      chk_flags("legal_island", 1'b0, 3'd0);

      // Legal video period
      hold(3'b111, 8);
      chk("vpre_ctrl0", 64'({if0.ch1_ctrl, if0.ch2_ctrl}), 64'(4'b0100));
      hold(3'b110, 2);
      chk_modes("vguard_modes0", 0, 6'b000000);
      chk("vguard_guard0", 64'(if0.ch2_guard), 64'(1));
      hold(3'b011, 20);
      chk_modes("video_modes0", 0, 6'b111111);
      chk_modes("video_modes1_dvi", 1, 6'b111111);
      hold(3'b000, 4);
      chk_flags("legal_video", 1'b0, 3'd0);

      // Short video preamble
      hold(3'b111, 7);
      hold(3'b110, 2);
      hold(3'b011, 4);
      hold(3'b000, 2);
      chk_flags("short_pre", 1'b1, 3'd1);
      clear_err();
      chk_flags("cleared", 1'b0, 3'd0);

      aux_island(40);
      chk_flags("adata40", 1'b1, 3'd3);
      clear_err();

      aux_island(19 * 32);
      chk_flags("adata19pk", 1'b1, 3'd4);

      // Three-cycle video guard with err_clear on the detecting cycle
      hold(3'b111, 8);
      hold(3'b110, 3);
      err_clear = 1'b1;
      hold(3'b011, 1);
      err_clear = 1'b0;
      hold(3'b011, 3);
      hold(3'b000, 2);
      chk_flags("clear_vs_guard", 1'b1, 3'd2);

      clear_err();
      hold(3'b011, 3);
      hold(3'b000, 2);
      chk_flags("video_from_ctrl", 1'b1, 3'd5);

      // Scaling, fixed pixels
      auto_pix = 1'b0;
      pixel0 = 8'd255; pixel1 = 8'd255; pixel2 = 8'd255;
      scale_mode = 2'b01; hold(3'b000, 4); chk_pix("lim255", 8'd237, 8'd237, 8'd237);
      scale_mode = 2'b10; hold(3'b000, 4); chk_pix("ycc255", 8'd252, 8'd237, 8'd252);
      scale_mode = 2'b00; hold(3'b000, 4); chk_pix("none255", 8'd255, 8'd255, 8'd255);
      scale_mode = 2'b11; hold(3'b000, 4); chk_pix("mode3_255", 8'd255, 8'd255, 8'd255);
      pixel0 = 8'd0; pixel1 = 8'd0; pixel2 = 8'd0;
      scale_mode = 2'b01; hold(3'b000, 4); chk_pix("lim0", 8'd16, 8'd16, 8'd16);
      pixel0 = 8'd100; pixel1 = 8'd100; pixel2 = 8'd100;
      scale_mode = 2'b10; hold(3'b000, 4); chk_pix("ycc100", 8'd109, 8'd103, 8'd109);
      auto_pix = 1'b1;

      // Reset in the middle of a video period, with seq_error still set
      hold(3'b111, 8);
      hold(3'b110, 2);
      hold(3'b011, 5);
      rst_n = 1'b0;
      #1;
      chk_modes("midrst_modes0", 0, 6'b101010);
      chk_modes("midrst_modes1", 1, 6'b101010);
      chk("midrst_guard0", 64'(if0.ch2_guard), 64'(0));
      chk_flags("midrst", 1'b0, 3'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      auto_pix = 1'b0;
      hsync = 1'b1; vsync = 1'b0;
      rst_n = 1'b1;
      hold(3'b000, 4);
      chk("post_rst_ctrl0", 64'(if0.ch0_ctrl), 64'(2'b01));
      chk("post_rst_ctrl1", 64'(if1.ch0_ctrl), 64'(2'b01));
      auto_pix = 1'b1;
      aux_island(32);
      chk_flags("post_rst_island", 1'b0, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
